// File: rtl/pc_sequencer.sv
// Fetch-stage next-PC generator with circular return-address stack; redirects land on pc_out one cycle later.
// Priority trap > flush > stall > RAS pop > predicted-taken > sequential; stall holds PC and freezes the RAS.
module pc_sequencer #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int               PC_INC       = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             stall,
    input  logic                             flush,
    input  logic [XLEN-1:0]                  new_pc,
    input  logic                             trap,
    input  logic [XLEN-1:0]                  trap_vector,
    input  logic                             pred_taken,
    input  logic [XLEN-1:0]                  pred_target,
    input  logic                             call,
    input  logic                             ret,
    output logic [XLEN-1:0]                  pc_out,
    output logic                             misalign,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_underflow
);
    localparam int              CW       = $clog2(RAS_DEPTH + 1);
    localparam int              PW       = $clog2(RAS_DEPTH);
    localparam logic [XLEN-1:0] INC      = XLEN'(PC_INC);
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(PC_INC - 1);
    localparam logic [CW-1:0]   FULL     = CW'(RAS_DEPTH);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RAS_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(RAS_DEPTH - 1) : p - PW'(1);
    endfunction

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]   r_wp;
    logic [CW-1:0]   r_count;
    logic            r_misalign;
    logic            r_underflow;

    logic [XLEN-1:0] w_seq;
    logic [PW-1:0]   w_top_idx;
    logic            w_pop_ok;
    logic [XLEN-1:0] w_pc_nxt;
    logic [PW-1:0]   w_wp_nxt;
    logic [CW-1:0]   w_count_nxt;
    logic            w_mis_nxt;
    logic            w_uf_nxt;
    logic            w_we;
    logic [PW-1:0]   w_widx;

    assign w_seq     = r_pc + INC;
    assign w_top_idx = ptr_dec(r_wp);
    assign w_pop_ok  = !trap && !flush && !stall && ret && (r_count != '0);

    always_comb begin
        w_pc_nxt    = w_seq;
        w_wp_nxt    = r_wp;
        w_count_nxt = r_count;
        w_mis_nxt   = 1'b0;
        w_uf_nxt    = 1'b0;
        w_we        = 1'b0;
        w_widx      = r_wp;
        if (trap) begin
            w_pc_nxt    = trap_vector & ~LOW_MASK;
            w_mis_nxt   = |(trap_vector & LOW_MASK);
            w_count_nxt = '0;
        end else if (flush) begin
            w_pc_nxt  = new_pc & ~LOW_MASK;
            w_mis_nxt = |(new_pc & LOW_MASK);
        end else if (stall) begin
            w_pc_nxt = r_pc;
        end else if (w_pop_ok) begin
            w_pc_nxt = r_ras[w_top_idx];
            // call+ret: the return address reuses the slot just popped
            if (call) begin
                w_we   = 1'b1;
                w_widx = w_top_idx;
            end else begin
                w_wp_nxt    = w_top_idx;
                w_count_nxt = r_count - CW'(1);
            end
        end else begin
            w_uf_nxt = ret;
            if (pred_taken) begin
                w_pc_nxt  = pred_target & ~LOW_MASK;
                w_mis_nxt = |(pred_target & LOW_MASK);
            end
            // a push into a full stack overwrites the oldest entry
            if (call) begin
                w_we        = 1'b1;
                w_wp_nxt    = ptr_inc(r_wp);
                w_count_nxt = (r_count == FULL) ? r_count : r_count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= RESET_VECTOR;
            r_wp        <= '0;
            r_count     <= '0;
            r_misalign  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_wp        <= w_wp_nxt;
            r_count     <= w_count_nxt;
            r_misalign  <= w_mis_nxt;
            r_underflow <= w_uf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_we) begin
            r_ras[w_widx] <= w_seq;
        end
    end

    assign pc_out        = r_pc;
    assign misalign      = r_misalign;
    assign ras_count     = r_count;
    assign ras_underflow = r_underflow;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written RAS sequences, random stimulus vs a queue model.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1, stall = 1'b0, flush = 1'b0, trap = 1'b0;
    logic        pred_taken = 1'b0, call = 1'b0, ret = 1'b0;
    logic [31:0] new_pc = '0, trap_vector = '0, pred_target = '0;
    logic [31:0] pc_out;
    logic        misalign, ras_underflow;
    logic [2:0]  ras_count;

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .PC_INC(4), .RAS_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
        .trap(trap), .trap_vector(trap_vector), .pred_taken(pred_taken),
        .pred_target(pred_target), .call(call), .ret(ret), .pc_out(pc_out),
        .misalign(misalign), .ras_count(ras_count), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    // control bits: {reset, trap, flush, stall, pred_taken, call, ret}
    localparam logic [6:0] R = 7'b1000000, T = 7'b0100000, F = 7'b0010000, S = 7'b0001000;
    localparam logic [6:0] P = 7'b0000100, C = 7'b0000010, Q = 7'b0000001, N = 7'b0000000;

    // reference model: stack as a bounded queue, top at the back
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_mis, m_uf;

    task automatic model_step();
        logic [31:0] nxt;
        logic [31:0] ret_addr;
        logic        mis, uf;
        nxt = m_pc + 32'd4;
        ret_addr = m_pc + 32'd4;
        mis = 1'b0;
        uf = 1'b0;
        if (reset) begin
            m_pc = 32'h0;
            m_ras.delete();
            m_mis = 1'b0;
            m_uf = 1'b0;
            return;
        end
        if (trap) begin
            nxt = {trap_vector[31:2], 2'b00};
            mis = (trap_vector[1:0] != 2'b00);
            m_ras.delete();
        end else if (flush) begin
            nxt = {new_pc[31:2], 2'b00};
            mis = (new_pc[1:0] != 2'b00);
        end else if (stall) begin
            nxt = m_pc;
        end else begin
            if (ret && m_ras.size() > 0) begin
                nxt = m_ras.pop_back();
            end else begin
                uf = ret;
                if (pred_taken) begin
                    nxt = {pred_target[31:2], 2'b00};
                    mis = (pred_target[1:0] != 2'b00);
                end
            end
            if (call) begin
                if (m_ras.size() == 4) void'(m_ras.pop_front());
                m_ras.push_back(ret_addr);
            end
        end
        m_pc = nxt;
        m_mis = mis;
        m_uf = uf;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic [6:0] ctl, input logic [31:0] a0, input logic [31:0] a1);
        {reset, trap, flush, stall, pred_taken, call, ret} = ctl;
        trap_vector = a0;
        new_pc      = a1;
        pred_target = a1;
    endtask

    // one clock: advance the model with the present inputs, then compare after the edge
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("model_pc", pc_out, m_pc);
        chk("model_cnt", {29'd0, ras_count}, m_ras.size());
        chk("model_mis", {31'd0, misalign}, {31'd0, m_mis});
        chk("model_uf", {31'd0, ras_underflow}, {31'd0, m_uf});
    endtask

    typedef struct {
        logic [6:0]  ctl;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] epc;
        logic [2:0]  ecnt;
        logic        emis;
        logic        euf;
    } vec_t;

    vec_t tbl[20];
    logic [31:0] exp_ret[5];

    initial begin
        tbl[0]  = '{R,     32'h0,   32'h0,    32'h0,    3'd0, 1'b0, 1'b0};
        tbl[1]  = '{R,     32'h0,   32'h0,    32'h0,    3'd0, 1'b0, 1'b0};
        tbl[2]  = '{N,     32'h0,   32'h0,    32'h4,    3'd0, 1'b0, 1'b0};
        tbl[3]  = '{N,     32'h0,   32'h0,    32'h8,    3'd0, 1'b0, 1'b0};
        tbl[4]  = '{S,     32'h0,   32'h0,    32'h8,    3'd0, 1'b0, 1'b0};
        tbl[5]  = '{S,     32'h0,   32'h0,    32'h8,    3'd0, 1'b0, 1'b0};
        tbl[6]  = '{S|F,   32'h0,   32'h1000, 32'h1000, 3'd0, 1'b0, 1'b0};
        tbl[7]  = '{N,     32'h0,   32'h0,    32'h1004, 3'd0, 1'b0, 1'b0};
        tbl[8]  = '{T|F,   32'h200, 32'h300,  32'h200,  3'd0, 1'b0, 1'b0};
        tbl[9]  = '{F,     32'h0,   32'h1002, 32'h1000, 3'd0, 1'b1, 1'b0};
        tbl[10] = '{N,     32'h0,   32'h0,    32'h1004, 3'd0, 1'b0, 1'b0};
        tbl[11] = '{F,     32'h0,   32'h10,   32'h10,   3'd0, 1'b0, 1'b0};
        tbl[12] = '{C|P,   32'h0,   32'h80,   32'h80,   3'd1, 1'b0, 1'b0};
        tbl[13] = '{N,     32'h0,   32'h0,    32'h84,   3'd1, 1'b0, 1'b0};
        tbl[14] = '{N,     32'h0,   32'h0,    32'h88,   3'd1, 1'b0, 1'b0};
        tbl[15] = '{Q|P,   32'h0,   32'h900,  32'h14,   3'd0, 1'b0, 1'b0};
        tbl[16] = '{Q,     32'h0,   32'h0,    32'h18,   3'd0, 1'b0, 1'b1};
        tbl[17] = '{N,     32'h0,   32'h0,    32'h1c,   3'd0, 1'b0, 1'b0};
        tbl[18] = '{S|C|Q, 32'h0,   32'h0,    32'h1c,   3'd0, 1'b0, 1'b0};
        tbl[19] = '{T|C,   32'h203, 32'h0,    32'h200,  3'd0, 1'b1, 1'b0};

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i].ctl, tbl[i].a0, tbl[i].a1);
            cycle();
            chk($sformatf("vec%0d_pc", i), pc_out, tbl[i].epc);
            chk($sformatf("vec%0d_cnt", i), {29'd0, ras_count}, {29'd0, tbl[i].ecnt});
            chk($sformatf("vec%0d_mis", i), {31'd0, misalign}, {31'd0, tbl[i].emis});
            chk($sformatf("vec%0d_uf", i), {31'd0, ras_underflow}, {31'd0, tbl[i].euf});
        end

        // five calls into a depth-4 stack, then five returns
        apply(F, 32'h0, 32'h0);
        cycle();
        for (int i = 1; i <= 5; i++) begin
            apply(C|P, 32'h0, 32'(i) << 8);
            cycle();
        end
        chk("deep_cnt", {29'd0, ras_count}, 32'd4);
        exp_ret = '{32'h404, 32'h304, 32'h204, 32'h104, 32'h108};
        for (int i = 0; i < 5; i++) begin
            apply(Q, 32'h0, 32'h0);
            cycle();
            chk($sformatf("deep_ret%0d", i), pc_out, exp_ret[i]);
        end
        chk("deep_uf", {31'd0, ras_underflow}, 32'd1);

        // address wrap
        apply(F, 32'h0, 32'hFFFF_FFFC);
        cycle();
        apply(N, 32'h0, 32'h0);
        cycle();
        chk("wrap_pc", pc_out, 32'h0);

        // call and ret together: redirect to old top, new top is pc+4
        apply(T, 32'h10, 32'h0);
        cycle();
        apply(C|P, 32'h0, 32'h40);
        cycle();
        apply(C|Q, 32'h0, 32'h0);
        cycle();
        chk("callret_pc", pc_out, 32'h14);
        chk("callret_cnt", {29'd0, ras_count}, 32'd1);
        apply(Q, 32'h0, 32'h0);
        cycle();
        chk("callret_top", pc_out, 32'h44);

        // reset mid-operation
        apply(C|P, 32'h0, 32'h500);
        cycle();
        apply(R|C|Q|P, 32'h0, 32'h700);
        cycle();
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_cnt", {29'd0, ras_count}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [6:0]  ctl;
            logic [31:0] a0, a1;
            ctl[6] = ($urandom_range(99) == 0);
            ctl[5] = ($urandom_range(19) == 0);
            ctl[4] = ($urandom_range(9) == 0);
            ctl[3] = ($urandom_range(5) == 0);
            ctl[2] = ($urandom_range(3) == 0);
            ctl[1] = ($urandom_range(2) == 0);
            ctl[0] = ($urandom_range(2) == 0);
            a0 = $urandom;
            a1 = $urandom;
            if ($urandom_range(1) == 0) a1[1:0] = 2'b00;
            apply(ctl, a0, a1);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
